// File: rtl/mdma_40bx512_ram_fifo_ctrl_if.sv
// mdma_40bx512_40bwe_ram_if: port bundle of the 40-bit x 512 ECC RAM (1-cycle read latency)
interface mdma_40bx512_40bwe_ram_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 40
);
    logic [ADDR_W-1:0] wadr;
    logic              wen;
    logic [DATA_W-1:0] wdat;
    logic              ren;
    logic [ADDR_W-1:0] radr;
    logic [DATA_W-1:0] rdat;
    logic              rsbe;
    logic              rdbe;
    modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);
    modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);
endinterface

// File: rtl/mdma_40bx512_ram_fifo_ctrl.sv
// mdma_40bx512_ram_fifo_ctrl: FIFO controller over a 1-cycle-latency ECC RAM with a 2-entry prefetch buffer
module mdma_40bx512_ram_fifo_ctrl #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 40,
    parameter int AFULL_THRESH = 480,
    parameter int SBE_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [DATA_W-1:0]    in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [DATA_W-1:0]    out_dat,
    output logic                 out_dbe,
    output logic                 afull,
    output logic [ADDR_W:0]      occupancy,
    output logic [SBE_CNT_W-1:0] sbe_cnt,
    output logic                 dbe_sticky,
    input  logic                 clr_err,
    mdma_40bx512_40bwe_ram_if.m  ram
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0]   ram_cnt, ram_cnt_n, occ_n;
    logic [1:0]        buf_cnt, buf_cnt_n, buf_dbe;
    logic [2:0]        demand;
    logic [DATA_W-1:0] buf_dat [2];
    logic              inflight, hd, wr, rd, pop;
    // Handshakes, read-issue decision and next-state counts; rst forces every RAM strobe low
    always_comb begin
        in_rdy    = ~rst & (ram_cnt != (ADDR_W+1)'(DEPTH));
        wr        = in_vld & in_rdy;
        out_vld   = ~rst & (buf_cnt != 2'd0);
        pop       = out_vld & out_rdy;
        demand    = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
        rd        = ~rst & (ram_cnt != '0) & (demand < 3'd2);
        out_dat   = out_vld ? buf_dat[hd] : '0;
        out_dbe   = out_vld & buf_dbe[hd];
        ram_cnt_n = ram_cnt + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
        buf_cnt_n = buf_cnt + 2'(inflight) - 2'(pop);
        occ_n     = ram_cnt_n + (ADDR_W+1)'(rd) + (ADDR_W+1)'(buf_cnt_n);
    end
    assign ram.wen  = wr;
    assign ram.wadr = rst ? '0 : wptr;
    assign ram.wdat = rst ? '0 : in_dat;
    assign ram.ren  = rd;
    assign ram.radr = rst ? '0 : rptr;
    // Pointers, counts and registered status; a read returning right after rst finds inflight=0 and is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            inflight  <= 1'b0;
            buf_cnt   <= '0;
            hd        <= 1'b0;
            occupancy <= '0;
            afull     <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + ADDR_W'(1);
            if (rd) rptr <= rptr + ADDR_W'(1);
            if (pop) hd <= ~hd;
            ram_cnt   <= ram_cnt_n;
            inflight  <= rd;
            buf_cnt   <= buf_cnt_n;
            occupancy <= occ_n;
            afull     <= occ_n >= (ADDR_W+1)'(AFULL_THRESH);
        end
    end
    // Returning word goes behind the live entries; issue throttling guarantees a free slot
    always_ff @(posedge clk) begin
        if (!rst && inflight) begin
            buf_dat[hd ^ buf_cnt[0]] <= ram.rdat;
            buf_dbe[hd ^ buf_cnt[0]] <= ram.rdbe;
        end
    end
    // ECC event bookkeeping; clr_err beats a coincident event
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            sbe_cnt    <= '0;
            dbe_sticky <= 1'b0;
        end else if (inflight) begin
            if (ram.rsbe && !(&sbe_cnt)) sbe_cnt <= sbe_cnt + SBE_CNT_W'(1);
            if (ram.rdbe) dbe_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mdma_40bx512_ram_fifo_ctrl.sv
// tb_mdma_40bx512_ram_fifo_ctrl: scoreboard bench with a behavioural ECC RAM
module tb_mdma_40bx512_ram_fifo_ctrl;
    logic        clk = 0, rst = 1, in_vld = 0, out_rdy = 0, clr_err = 0;
    logic [39:0] in_dat = '0;
    logic        in_rdy, out_vld, out_dbe, afull, dbe_sticky;
    logic [39:0] out_dat;
    logic [9:0]  occupancy;
    logic [15:0] sbe_cnt;
    int          n_chk = 0, n_fail = 0;

    mdma_40bx512_40bwe_ram_if ram_if();

    mdma_40bx512_ram_fifo_ctrl dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_dbe(out_dbe),
        .afull(afull), .occupancy(occupancy), .sbe_cnt(sbe_cnt), .dbe_sticky(dbe_sticky),
        .clr_err(clr_err), .ram(ram_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // behavioural RAM with per-address error injection
    logic [39:0]  mem [512];
    logic [511:0] sbe_flag = '0, dbe_flag = '0;
    initial begin
        ram_if.rdat = '0;
        ram_if.rsbe = 1'b0;
        ram_if.rdbe = 1'b0;
    end
    always @(posedge clk) begin
        if (ram_if.wen) mem[ram_if.wadr] <= ram_if.wdat;
        ram_if.rsbe <= ram_if.ren & sbe_flag[ram_if.radr];
        ram_if.rdbe <= ram_if.ren & dbe_flag[ram_if.radr];
        if (ram_if.ren) ram_if.rdat <= mem[ram_if.radr];
    end

    // scoreboard and cycle model
    logic [40:0] sbq [$];
    logic [8:0]  wm = '0, rm = '0;
    int          occ_m = 0, ram_m = 0, buf_m = 0;
    logic        inf_m = 0, stall_prev = 0, stream_chk = 0;
    logic [39:0] last_dat = '0;

    always @(negedge clk) begin : mon
        logic p, w, r;
        logic [40:0] e;
        if (rst) begin
            chk("rst_in_rdy", 64'(in_rdy), 64'd0);
            chk("rst_ren", 64'(ram_if.ren), 64'd0);
            chk("rst_wen", 64'(ram_if.wen), 64'd0);
            chk("rst_out_vld", 64'(out_vld), 64'd0);
            sbq.delete();
            wm = '0; rm = '0; occ_m = 0; ram_m = 0; buf_m = 0; inf_m = 0; stall_prev = 0;
        end else begin
            p = out_vld & out_rdy;
            w = in_vld & in_rdy;
            r = ram_if.ren;
            chk("occupancy", 64'(occupancy), 64'(occ_m));
            chk("afull", 64'(afull), 64'(occ_m >= 480));
            chk("in_rdy", 64'(in_rdy), 64'(ram_m != 512));
            chk("ren", 64'(r), 64'(ram_m != 0 && buf_m + int'(inf_m) - int'(p) < 2));
            chk("out_vld", 64'(out_vld), 64'(buf_m != 0));
            if (stall_prev) begin
                chk("stall_vld", 64'(out_vld), 64'd1);
                chk("stall_dat", 64'(out_dat), 64'(last_dat));
            end
            if (stream_chk) chk("stream_gap", 64'(out_vld), 64'd1);
            if (w) begin
                chk("wadr", 64'(ram_if.wadr), 64'(wm));
                sbq.push_back({dbe_flag[wm], in_dat});
                wm = wm + 9'd1;
            end
            if (r) begin
                chk("radr", 64'(ram_if.radr), 64'(rm));
                rm = rm + 9'd1;
            end
            if (p) begin
                if (sbq.size() == 0) chk("pop_empty", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("out_dat", 64'(out_dat), 64'(e[39:0]));
                    chk("out_dbe", 64'(out_dbe), 64'(e[40]));
                end
            end
            occ_m = occ_m + int'(w) - int'(p);
            ram_m = ram_m + int'(w) - int'(r);
            buf_m = buf_m + int'(inf_m) - int'(p);
            inf_m = r;
            stall_prev = out_vld & ~out_rdy;
            last_dat = out_dat;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [39:0] d);
        int t = 0;
        in_vld = 1'b1;
        in_dat = d;
        while (!in_rdy && t < 1000) begin
            cyc(1);
            t++;
        end
        if (t >= 1000) chk("put_timeout", 64'd0, 64'd1);
        cyc(1);
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_rdy = 1'b1;
        while (sbq.size() != 0 && t < 3000) begin
            cyc(1);
            t++;
        end
        chk("drain_done", 64'(t < 3000), 64'd1);
        cyc(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [8:0]  a;
        logic [63:0] rnd;
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_vld", 64'(out_vld), 64'd0);
        chk("reset_out_dat", 64'(out_dat), 64'd0);
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_in_rdy", 64'(in_rdy), 64'd1);
        chk("reset_sbe", 64'(sbe_cnt), 64'd0);
        chk("reset_dbe", 64'(dbe_sticky), 64'd0);
        chk("reset_afull", 64'(afull), 64'd0);

        // single word latency
        cyc(1);
        out_rdy = 1'b1;
        in_vld = 1'b1;
        in_dat = 40'h12_3456_789A;
        cyc(1);
        in_vld = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_vld) break;
            lat++;
        end
        chk("single_latency", 64'(lat), 64'd3);
        chk("single_dat", 64'(out_dat), 64'h12_3456_789A);
        cyc(3);
        chk("single_occ", 64'(occupancy), 64'd0);

        // fill to full with the reader stalled, then drain across the pointer wrap
        out_rdy = 1'b0;
        for (int i = 0; i < 514; i++) put(40'hA0_0000_0000 | 40'(i));
        chk("full_in_rdy", 64'(in_rdy), 64'd0);
        chk("full_afull", 64'(afull), 64'd1);
        chk("full_occ", 64'(occupancy), 64'd514);
        in_vld = 1'b1;
        in_dat = 40'hDEAD;
        cyc(3);
        in_vld = 1'b0;
        drain();
        chk("fill_empty_occ", 64'(occupancy), 64'd0);

        // streaming
        out_rdy = 1'b1;
        in_vld = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_dat = 40'(i) | 40'h33_0000_0000;
            cyc(1);
            if (i == 5) stream_chk = 1'b1;
        end
        stream_chk = 1'b0;
        in_vld = 1'b0;
        drain();

        // random backpressure
        for (int i = 0; i < 1500; i++) begin
            rnd = {$urandom, $urandom};
            in_vld = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            in_dat = rnd[39:0];
            cyc(1);
        end
        in_vld = 1'b0;
        drain();

        // ECC: three single-bit and one double-bit event
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        a = wm;
        sbe_flag[a] = 1'b1;
        sbe_flag[a + 9'd1] = 1'b1;
        sbe_flag[a + 9'd2] = 1'b1;
        dbe_flag[a + 9'd4] = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) put(40'hEC_0000_0000 | 40'(i));
        drain();
        chk("ecc_sbe_cnt", 64'(sbe_cnt), 64'd3);
        chk("ecc_dbe_sticky", 64'(dbe_sticky), 64'd1);
        sbe_flag = '0;
        dbe_flag = '0;

        // clr_err beats a coincident rsbe
        sbe_flag[wm] = 1'b1;
        put(40'hEC_FFFF_0001);
        lat = 0;
        while (lat < 10) begin
            if (ram_if.rsbe) break;
            cyc(1);
            lat++;
        end
        chk("clr_rsbe_seen", 64'(lat < 10), 64'd1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("clr_sbe_cnt", 64'(sbe_cnt), 64'd0);
        chk("clr_dbe_sticky", 64'(dbe_sticky), 64'd0);
        sbe_flag = '0;
        drain();

        // reset mid-stream
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) put(40'h77_0000_0000 | 40'(i));
        out_rdy = 1'b1;
        in_vld = 1'b1;
        in_dat = 40'h77_0000_00FF;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        chk("midrst_out_vld", 64'(out_vld), 64'd0);
        chk("midrst_occ", 64'(occupancy), 64'd0);
        cyc(4);
        chk("midrst_late_vld", 64'(out_vld), 64'd0);
        in_vld = 1'b1;
        in_dat = 40'h55_AA55_AA55;
        chk("midrst_wadr", 64'(ram_if.wadr), 64'd0);
        cyc(1);
        in_vld = 1'b0;
        drain();
        chk("midrst_final_occ", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
